// File: rtl/rr_sel_mux2.sv
// Two-source round-robin arbiter feeding a one-entry registered 2:1 output stage.
// Alternates on contention and respects downstream backpressure via valid/ready.
module rr_sel_mux2 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i0,
    input  logic             i0_valid,
    output logic             i0_ready,
    input  logic [WIDTH-1:0] i1,
    input  logic             i1_valid,
    output logic             i1_ready,
    output logic [WIDTH-1:0] y,
    output logic             y_valid,
    input  logic             y_ready,
    output logic             s
);

    // state  | meaning
    // EMPTY  | output register holds no beat
    // FULL   | output register holds a beat tagged by s
    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    logic [0:0]       r_state;
    logic             r_last;
    logic [WIDTH-1:0] r_y;
    logic             r_s;

    logic             w_out_free;
    logic             w_g;
    logic             w_accept;
    logic             w_pop;

    assign y_valid = (r_state == ST_FULL);
    assign y       = r_y;
    assign s       = r_s;

    // Gating with rst keeps both readies low while reset is asserted.
    assign w_out_free = !rst && (!y_valid || y_ready);
    assign w_pop      = y_valid && y_ready;
    assign w_accept   = w_out_free && (i0_valid || i1_valid);

    always_comb begin
        w_g = 1'b0;
        if (i0_valid && i1_valid) begin
            w_g = ~r_last;
        end else if (i1_valid) begin
            w_g = 1'b1;
        end
    end

    assign i0_ready = w_out_free && i0_valid && !w_g;
    assign i1_ready = w_out_free && i1_valid &&  w_g;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_EMPTY;
            r_last  <= 1'b1;
            r_y     <= '0;
            r_s     <= 1'b0;
        end else begin
            case (r_state)
                ST_EMPTY: if (w_accept)            r_state <= ST_FULL;
                ST_FULL:  if (w_pop && !w_accept)  r_state <= ST_EMPTY;
                default:                           r_state <= ST_EMPTY;
            endcase
            // Pointer moves only on an accepted beat; idle cycles leave it alone.
            if (w_accept) begin
                r_y    <= w_g ? i1 : i0;
                r_s    <= w_g;
                r_last <= w_g;
            end
        end
    end

endmodule

// File: tb/tb_rr_sel_mux2.sv
// Self-checking bench for rr_sel_mux2: directed scenarios plus randomized traffic
// compared cycle by cycle against a behavioural arbitration model.
module tb_rr_sel_mux2;

    logic       clk;
    logic       rst;
    logic [7:0] i0, i1;
    logic       i0_valid, i1_valid, y_ready;
    logic       i0_ready, i1_ready;
    logic [7:0] y;
    logic       y_valid, s;

    int n_checks = 0;
    int n_errors = 0;

    // behavioural model state
    bit       m_known = 0;
    bit       m_full  = 0;
    bit [7:0] m_y     = 0;
    bit       m_s     = 0;
    int       m_last_src = 1;

    rr_sel_mux2 #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst),
        .i0(i0), .i0_valid(i0_valid), .i0_ready(i0_ready),
        .i1(i1), .i1_valid(i1_valid), .i1_ready(i1_ready),
        .y(y), .y_valid(y_valid), .y_ready(y_ready), .s(s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock of stimulus: drive at negedge, check, then advance the model at posedge.
    task automatic cycle(input bit r, input bit [7:0] d0, input bit v0,
                         input bit [7:0] d1, input bit v1, input bit yr);
        bit [7:0] src_data [2];
        bit       free;
        int       winner;
        @(negedge clk);
        rst = r; i0 = d0; i0_valid = v0; i1 = d1; i1_valid = v1; y_ready = yr;
        #1;
        src_data[0] = d0;
        src_data[1] = d1;
        free   = !r && (!m_full || yr);
        winner = -1;
        if (free) begin
            if (v0 && v1)  winner = 1 - m_last_src;
            else if (v0)   winner = 0;
            else if (v1)   winner = 1;
        end
        chk("i0_ready", i0_ready, (winner == 0));
        chk("i1_ready", i1_ready, (winner == 1));
        if (m_known) begin
            chk("y_valid", y_valid, m_full);
            chk("y", y, m_y);
            chk("s", s, m_s);
        end
        @(posedge clk);
        if (r) begin
            m_known = 1; m_full = 0; m_y = 0; m_s = 0; m_last_src = 1;
        end else if (winner >= 0) begin
            m_full = 1; m_y = src_data[winner]; m_s = (winner == 1); m_last_src = winner;
        end else if (m_full && yr) begin
            m_full = 0;
        end
    endtask

    task automatic do_reset(input int n);
        for (int k = 0; k < n; k++) cycle(1, 8'($urandom), 1'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
    endtask

    logic [7:0] seq_y [4];
    logic       seq_s [4];

    initial begin
        rst = 1; i0 = 0; i1 = 0; i0_valid = 0; i1_valid = 0; y_ready = 0;

        // reset
        do_reset(2);
        #2;
        chk("rst_y", y, 8'h00);
        chk("rst_y_valid", y_valid, 1'b0);
        chk("rst_s", s, 1'b0);

        // single source
        cycle(0, 8'h3C, 1, 8'h00, 0, 1);
        #2;
        chk("single_y", y, 8'h3C);
        chk("single_s", s, 1'b0);
        chk("single_y_valid", y_valid, 1'b1);

        // contention alternates starting with i0
        do_reset(1);
        for (int k = 0; k < 4; k++) begin
            cycle(0, 8'hA0, 1, 8'hB1, 1, 1);
            #2;
            seq_y[k] = y;
            seq_s[k] = s;
        end
        chk("cont_y0", seq_y[0], 8'hA0);
        chk("cont_y1", seq_y[1], 8'hB1);
        chk("cont_y2", seq_y[2], 8'hA0);
        chk("cont_y3", seq_y[3], 8'hB1);
        chk("cont_s", {seq_s[0], seq_s[1], seq_s[2], seq_s[3]}, 4'b0101);

        // backpressure holding a beat from i1
        do_reset(1);
        cycle(0, 8'h00, 0, 8'h55, 1, 1);
        for (int k = 0; k < 3; k++) begin
            cycle(0, 8'h11, 1, 8'h22, 1, 0);
            #2;
            chk("bp_y", y, 8'h55);
            chk("bp_s", s, 1'b1);
            chk("bp_rdy", {i0_ready, i1_ready}, 2'b00);
        end
        cycle(0, 8'h11, 1, 8'h22, 1, 1);
        #2;
        chk("bp_release_y", y, 8'h11);
        chk("bp_release_s", s, 1'b0);

        // reset mid-operation
        do_reset(1);
        cycle(0, 8'h77, 1, 8'h00, 0, 0);
        #2;
        chk("mid_y_before", y, 8'h77);
        cycle(1, 8'h12, 1, 8'h34, 1, 0);
        #2;
        chk("mid_y_valid", y_valid, 1'b0);
        chk("mid_y", y, 8'h00);
        cycle(0, 8'h12, 1, 8'h34, 1, 1);
        #2;
        chk("mid_first_win", s, 1'b0);

        // pointer holds across idle cycles
        do_reset(1);
        cycle(0, 8'h00, 0, 8'h99, 1, 1);
        for (int k = 0; k < 5; k++) cycle(0, 8'h00, 0, 8'h00, 0, 1);
        cycle(0, 8'h5A, 1, 8'hA5, 1, 1);
        #2;
        chk("hold_y", y, 8'h5A);
        chk("hold_s", s, 1'b0);

        // randomized traffic against the model
        for (int k = 0; k < 3000; k++) begin
            cycle(($urandom_range(0, 59) == 0),
                  8'($urandom), ($urandom_range(0, 3) != 0),
                  8'($urandom), ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 2) != 0));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
